// File: rtl/simmem_bank_timer_if.sv
// Request/completion bundle between the delay calculator and the bank timer.
// Parameters must match the timer instance that uses it.
interface simmem_bank_timer_if #(
    parameter int AddrW    = 19,
    parameter int IidW     = 3,
    parameter int BankOutW = 2
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [AddrW-1:0]    req_addr_i;
    logic [IidW-1:0]     req_iid_i;
    logic                done_valid_o;
    logic                done_ready_i;
    logic [IidW-1:0]     done_iid_o;
    logic [BankOutW-1:0] done_bank_o;

    modport master (
        output req_valid_i, req_addr_i, req_iid_i, done_ready_i,
        input  req_ready_o, done_valid_o, done_iid_o, done_bank_o
    );

    modport slave (
        input  req_valid_i, req_addr_i, req_iid_i, done_ready_i,
        output req_ready_o, done_valid_o, done_iid_o, done_bank_o
    );
endinterface

// File: rtl/simmem_bank_timer.sv
// Multi-bank DRAM timing engine: per-bank open-row tracking, latency countdown
// and round-robin completion. SIMMEM_BANK_CLOSED_PAGE_EN selects closed-page.
module simmem_bank_timer #(
    parameter int AddrW          = 19,
    parameter int RowBufLenW     = 10,
    parameter int NumBanks       = 4,
    parameter int IidW           = 3,
    parameter int DelayW         = 6,
    parameter int RowHitCost     = 4,
    parameter int PrechargeCost  = 2,
    parameter int ActivationCost = 1
) (
    input logic clk_i,
    input logic rst_ni,
    simmem_bank_timer_if.slave bus
);
    localparam int BankW   = (NumBanks > 1) ? $clog2(NumBanks) : 0;
    localparam int BW      = (BankW > 0) ? BankW : 1;
    localparam int RowW    = AddrW - RowBufLenW - BankW;
    localparam int MaxCost = PrechargeCost + ActivationCost + RowHitCost;

    // Configuration sanity checked at elaboration
    if (MaxCost >= (1 << DelayW)) begin : g_cost_chk
        $error("simmem_bank_timer: maximum cost does not fit DelayW");
    end
    if (RowHitCost < 3) begin : g_hit_chk
        $error("simmem_bank_timer: RowHitCost must be at least 3");
    end

    logic [BW-1:0]       req_bank;
    logic [RowW-1:0]     req_row;
    logic [DelayW-1:0]   cost;
    logic                accept;

    logic [NumBanks-1:0] busy;
    logic [NumBanks-1:0] pending;
    logic [NumBanks-1:0] open_valid;
    logic [RowW-1:0]     open_row [NumBanks];
    logic [DelayW-1:0]   cnt [NumBanks];
    logic [IidW-1:0]     iid [NumBanks];

    logic [BW-1:0]       ptr;
    logic [BW-1:0]       rr_bank;
    logic [BW-1:0]       idx;
    logic                found;
    logic [BW-1:0]       grant;
    logic                hold_valid;
    logic [BW-1:0]       hold_bank;
    logic                any_pending;
    logic                done_fire;

    logic                unused_col;
    assign unused_col = ^bus.req_addr_i[RowBufLenW-1:0];

    if (NumBanks > 1) begin : g_bank_sel
        assign req_bank = bus.req_addr_i[RowBufLenW+BankW-1:RowBufLenW];
    end else begin : g_bank_one
        assign req_bank = '0;
    end
    assign req_row = bus.req_addr_i[AddrW-1:RowBufLenW+BankW];

    assign bus.req_ready_o = !busy[req_bank];
    assign accept          = bus.req_valid_i && bus.req_ready_o;

`ifdef SIMMEM_BANK_CLOSED_PAGE_EN
    logic unused_row;
    assign unused_row = ^req_row ^ (^open_valid);

    // Closed page: every access activates, reads and auto-precharges
    always_comb begin
        cost = DelayW'(ActivationCost + RowHitCost + PrechargeCost);
    end
`else
    // Open page: cost depends on the row currently held in the bank
    always_comb begin
        cost = DelayW'(ActivationCost + RowHitCost);
        if (open_valid[req_bank]) begin
            if (open_row[req_bank] == req_row) begin
                cost = DelayW'(RowHitCost);
            end else begin
                cost = DelayW'(MaxCost);
            end
        end
    end
`endif

    // Round-robin search for the first pending bank starting at the pointer
    always_comb begin
        rr_bank = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < NumBanks; i++) begin
            idx = BW'((int'(ptr) + i) % NumBanks);
            if (!found && pending[idx]) begin
                rr_bank = idx;
                found   = 1'b1;
            end
        end
    end

    // A stalled completion keeps its grant so outputs stay stable
    assign grant            = hold_valid ? hold_bank : rr_bank;
    assign any_pending      = |pending;
    assign done_fire        = any_pending && bus.done_ready_i;
    assign bus.done_valid_o = any_pending;
    assign bus.done_iid_o   = any_pending ? iid[grant] : '0;
    assign bus.done_bank_o  = any_pending ? grant : '0;

    // Per-bank acceptance, countdown and release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy       <= '0;
            pending    <= '0;
            open_valid <= '0;
            for (int b = 0; b < NumBanks; b++) begin
                open_row[b] <= '0;
                cnt[b]      <= '0;
                iid[b]      <= '0;
            end
        end else begin
            for (int b = 0; b < NumBanks; b++) begin
                if (accept && req_bank == BW'(b)) begin
                    busy[b] <= 1'b1;
                    cnt[b]  <= cost - DelayW'(1);
                    iid[b]  <= bus.req_iid_i;
`ifndef SIMMEM_BANK_CLOSED_PAGE_EN
                    open_valid[b] <= 1'b1;
                    open_row[b]   <= req_row;
`endif
                end else if (done_fire && grant == BW'(b)) begin
                    busy[b]    <= 1'b0;
                    pending[b] <= 1'b0;
                end else if (busy[b] && !pending[b]) begin
                    if (cnt[b] != '0) begin
                        cnt[b] <= cnt[b] - DelayW'(1);
                    end else begin
                        pending[b] <= 1'b1;
                    end
                end
            end
        end
    end

    // Arbiter pointer and grant hold across back-pressure
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr        <= '0;
            hold_valid <= 1'b0;
            hold_bank  <= '0;
        end else if (done_fire) begin
            ptr        <= BW'((int'(grant) + 1) % NumBanks);
            hold_valid <= 1'b0;
        end else if (any_pending) begin
            hold_valid <= 1'b1;
            hold_bank  <= grant;
        end
    end
endmodule

// File: doc/simmem_bank_timer.md
Name: simmem_bank_timer

Overview:
- Multi-bank DRAM timing engine for the simulated memory controller.
- Tracks the open row of each of NumBanks banks and computes each accepted request's latency from row-hit, precharge and activation costs.
- Counts the latency down per bank and returns the request's internal identifier on a done channel.
- Sits between the delay calculator's request issue and the response banks; it generalises the single-bank row-buffer cost model to N banks with concurrent operation.

Parameters:
- AddrW, 19, request address width (global memory capacity log2)
- RowBufLenW, 10, log2 of row-buffer width in bytes; column bits addr[RowBufLenW-1:0]
- NumBanks, 4, number of banks; power of two, at least 1
- IidW, 3, internal identifier width
- DelayW, 6, counter width
- RowHitCost, 4, cycles for a row hit; at least 3
- PrechargeCost, 2, cycles to close an open row
- ActivationCost, 1, cycles to open a row

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_addr_i  in  AddrW  byte address
- req_iid_i  in  IidW  internal identifier (write_iid_t/read_iid_t, zero-extended)
- done_valid_o  out  1  completion valid
- done_ready_i  in  1  completion ready
- done_iid_o  out  IidW  identifier of the completed request
- done_bank_o  out  max(1,$clog2(NumBanks))  bank that completed

Behaviour:
- Address split:
  - BankW = $clog2(NumBanks).
  - bank = addr[RowBufLenW+BankW-1:RowBufLenW]; bank is 0 when NumBanks=1.
  - row = addr[AddrW-1:RowBufLenW+BankW].
- Per-bank state: open_valid, open_row, busy, cnt[DelayW], iid, pending.
- Reset (async, immediate): all banks closed, not busy, counters 0, round-robin pointer 0. Outputs: req_ready_o=1, done_valid_o=0, done_iid_o=0, done_bank_o=0. A reset mid-operation discards all in-flight requests; no done is issued for them.
- req_ready_o = !busy[bank(req_addr_i)], combinational on the address. Handshake = valid & ready.
- Cost at acceptance:
  - Open and same row: RowHitCost.
  - Closed: ActivationCost + RowHitCost.
  - Open and different row: PrechargeCost + ActivationCost + RowHitCost.
  - Elaboration assertion: the maximum cost is < 2^DelayW.
- On acceptance:
  - busy=1, cnt=cost-1, iid latched.
  - open_valid=1, open_row=row, both updated at the accepting edge.
- While busy and cnt!=0: decrement each cycle. When cnt reaches 0, pending=1 on the next edge.
- Latency: a request accepted at edge t has done_valid_o high from edge t+cost, with done_ready_i held high.
- Done channel:
  - Round-robin arbiter over pending banks, starting at the pointer.
  - done_valid_o = any pending; done_iid_o/done_bank_o from the granted bank. When nothing is pending, done_iid_o and done_bank_o are 0.
  - Outputs stay stable while done_valid_o & !done_ready_i.
  - On handshake: the granted bank clears pending and busy, and the pointer becomes granted+1 mod NumBanks.
- Freed bank readiness: a freed bank is ready from the cycle after the done handshake. There is no same-cycle accept on a bank that is completing.
- Simultaneous events:
  - Different banks may accept and complete in the same cycle independently.
  - Multiple banks reaching pending in the same cycle are served in round-robin order.
- Back-pressure: a stalled done keeps its bank busy. Requests to that bank see req_ready_o=0, while other banks continue to accept.
- Counters never wrap: cnt holds at 0 while pending.

Optional Feature:
- Macro: SIMMEM_BANK_CLOSED_PAGE_EN.
- Defined (closed-page policy):
  - Every access costs ActivationCost + RowHitCost + PrechargeCost, with the auto-precharge time included in the request latency.
  - open_valid is never set; it stays 0.
- Undefined: open-page policy as described in Behaviour.

Test Plan:
- Reset, then a request to addr 0x00000 with iid 5 and done_ready=1 -> accepted at edge t; done_valid at t+5 with iid 5, bank 0; req_ready for bank 0 returns the following cycle.
- Then a request to 0x00010 (same bank/row) -> latency 4. Then 0x10000 (bank 0, row 0x10) -> latency 7. Closed-page build: all three -> latency 7.
- Requests to banks 0,1,2 (0x00000, 0x00400, 0x00800) accepted on three consecutive cycles -> done in order 0,1,2 at t+5, t+6, t+7.
- Banks 1 and 3 become pending in the same cycle with the pointer at 0, done_ready low for 3 cycles -> bank 1 outputs held stable for 3 cycles; then bank 1 completes, then bank 3; a request to bank 3 during the stall -> req_ready=0; a request to bank 2 -> accepted.
- Reset asserted 2 cycles after accepting a request to bank 2 -> done_valid is never raised; bank 2 is ready and closed, so the next access costs 5.
